// File: rtl/sram_req_ctrl.sv
// Valid/ready front end for the single-port 16K x 32 SRAM macro.
// Drives the macro pins directly from accepted requests and returns in-order responses through a small buffer.
module sram_req_ctrl #(
    parameter logic [31:0] BASE      = 32'h0000_0000,
    parameter int          RSP_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [31:0] i_req_addr,
    input  logic [3:0]  i_req_byte,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_sram_cs,
    output logic        o_sram_we,
    output logic [13:0] o_sram_a,
    output logic [3:0]  o_sram_byte,
    output logic [31:0] o_sram_di,
    input  logic [31:0] i_sram_do
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

    // Pointers wrap explicitly so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_LAST) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    logic             r_pend_v;
    logic             r_pend_write;
    logic             r_pend_err;
    logic [31:0]      r_buf_data [RSP_DEPTH];
    logic             r_buf_err  [RSP_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic             w_hit;
    logic             w_req_fire;
    logic             w_rsp_fire;
    logic [CNT_W-1:0] w_occ;
    logic [31:0]      w_push_data;
    logic [CNT_W-1:0] w_count_nxt;

    assign w_hit       = (i_req_addr[31:16] == BASE[31:16]);
    assign w_rsp_fire  = o_rsp_valid & i_rsp_ready;
    assign w_occ       = r_count + CNT_W'(r_pend_v);
    // A pop in this cycle frees a slot for the request accepted in the same cycle.
    assign o_req_ready = !i_rst && ((w_occ - CNT_W'(w_rsp_fire)) < DEPTH_C);
    assign w_req_fire  = i_req_valid & o_req_ready;

    assign o_sram_cs   = w_req_fire & w_hit;
    assign o_sram_we   = i_req_write;
    assign o_sram_a    = i_req_addr[15:2];
    assign o_sram_byte = i_req_byte;
    assign o_sram_di   = i_req_wdata;

    assign w_push_data = (!r_pend_write && !r_pend_err) ? i_sram_do : 32'h0000_0000;

    assign o_rsp_valid = (r_count != {CNT_W{1'b0}});
    assign o_rsp_rdata = o_rsp_valid ? r_buf_data[r_rd_ptr] : 32'h0000_0000;
    assign o_rsp_err   = o_rsp_valid ? r_buf_err[r_rd_ptr]  : 1'b0;

    // Next buffer occupancy from push (pending stage) and pop (response handshake).
    always_comb begin
        w_count_nxt = r_count;
        case ({r_pend_v, w_rsp_fire})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Pending stage: remembers what was issued so the DO capture next cycle is tagged correctly.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pend_v     <= 1'b0;
            r_pend_write <= 1'b0;
            r_pend_err   <= 1'b0;
        end else begin
            r_pend_v     <= w_req_fire;
            r_pend_write <= i_req_write;
            r_pend_err   <= !w_hit;
        end
    end

    // Response buffer storage, pointers and occupancy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_buf_data[i] <= 32'h0000_0000;
                r_buf_err[i]  <= 1'b0;
            end
            r_wr_ptr <= {PTR_W{1'b0}};
            r_rd_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (r_pend_v) begin
                r_buf_data[r_wr_ptr] <= w_push_data;
                r_buf_err[r_wr_ptr]  <= r_pend_err;
                r_wr_ptr             <= ptr_next(r_wr_ptr);
            end
            if (w_rsp_fire) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Self-checking bench for sram_req_ctrl: behavioural SRAM macro, reference memory and response scoreboard.
module tb_sram_req_ctrl;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [3:0]  req_byte;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        sram_cs;
    logic        sram_we;
    logic [13:0] sram_a;
    logic [3:0]  sram_byte;
    logic [31:0] sram_di;
    logic [31:0] sram_do;

    logic [31:0] mem     [16384];
    logic [31:0] ref_mem [16384];
    logic [32:0] sq[$];

    int n_total;
    int n_bad;
    int pops;
    logic [31:0] last_rdata;
    logic        last_err;

    sram_req_ctrl #(.BASE(32'h0000_0000), .RSP_DEPTH(2)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_write(req_write), .i_req_addr(req_addr),
        .i_req_byte(req_byte), .i_req_wdata(req_wdata),
        .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
        .o_sram_cs(sram_cs), .o_sram_we(sram_we), .o_sram_a(sram_a),
        .o_sram_byte(sram_byte), .o_sram_di(sram_di), .i_sram_do(sram_do)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Behavioural SRAM macro: registered pins, byte-masked write, 1-cycle read.
    initial for (int i = 0; i < 16384; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++)
                    if (sram_byte[b]) mem[sram_a][b*8 +: 8] <= sram_di[b*8 +: 8];
            end else begin
                sram_do <= mem[sram_a];
            end
        end
    end

    // Monitor: pin check, scoreboard push on req_fire, pop/compare on rsp_fire.
    always @(negedge clk) begin
        logic        fire;
        logic        hit;
        logic [31:0] exp_d;
        logic [32:0] e;
        if (!rst) begin
            fire = req_valid & req_ready;
            hit  = (req_addr[31:16] == 16'h0000);
            check("sram_cs", {31'd0, sram_cs}, {31'd0, fire & hit});
            if (fire) begin
                if (!hit) begin
                    sq.push_back({32'h0, 1'b1});
                end else if (req_write) begin
                    exp_d = ref_mem[req_addr[15:2]];
                    for (int b = 0; b < 4; b++)
                        if (req_byte[b]) exp_d[b*8 +: 8] = req_wdata[b*8 +: 8];
                    ref_mem[req_addr[15:2]] = exp_d;
                    sq.push_back({32'h0, 1'b0});
                end else begin
                    sq.push_back({ref_mem[req_addr[15:2]], 1'b0});
                end
            end
            if (rsp_valid && rsp_ready) begin
                if (sq.size() == 0) begin
                    check("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = sq.pop_front();
                    check("rsp_rdata", rsp_rdata, e[32:1]);
                    check("rsp_err", {31'd0, rsp_err}, {31'd0, e[0]});
                end
                pops++;
                last_rdata = rsp_rdata;
                last_err   = rsp_err;
            end
        end
    end

    // Drive a request and wait (bounded) until it is accepted; leaves req_valid high.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, output int waits);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_byte = be; req_wdata = wd;
        waits = 0;
        @(negedge clk);
        while (!req_ready && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        if (waits >= 50) check("issue_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic single(input logic wr, input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd);
        int w;
        issue(wr, addr, be, wd, w);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sq.size() != 0 || rsp_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) check("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int w;
        int max_w;
        int acc;
        n_total = 0; n_bad = 0; pops = 0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0;
        req_byte = 4'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Full write then read with latency check on an empty buffer.
        single(1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        drain();
        check("wr_rsp_rdata", last_rdata, 32'h0);
        single(1'b0, 32'h10, 4'h0, 32'h0);
        @(negedge clk);
        check("lat_t1_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        check("lat_t2_valid", {31'd0, rsp_valid}, 32'd1);
        drain();
        check("rd_deadbeef", last_rdata, 32'hDEAD_BEEF);

        // Partial byte write over all-ones.
        single(1'b1, 32'h20, 4'hF, 32'hFFFF_FFFF);
        single(1'b1, 32'h20, 4'b0101, 32'h1122_3344);
        single(1'b0, 32'h20, 4'h0, 32'h0);
        drain();
        check("partial_wr", last_rdata, 32'hFF22_FF44);

        // Back-to-back writes then reads over 0x0..0x3C.
        for (int i = 0; i < 16; i++) issue(1'b1, 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i), w);
        req_valid = 1'b0;
        drain();
        pops = 0; max_w = 0;
        for (int i = 0; i < 16; i++) begin
            issue(1'b0, 32'(i * 4), 4'h0, 32'h0, w);
            if (w > max_w) max_w = w;
        end
        req_valid = 1'b0;
        drain();
        check("b2b_no_stall", 32'(max_w), 32'd0);
        check("b2b_rsp_count", 32'(pops), 32'd16);

        // Backpressure: exactly two accepted, then stalled with CS low.
        rsp_ready = 1'b0; acc = 0; pops = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h4;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (req_valid && req_ready) acc++;
            @(posedge clk); #1;
            req_addr = (acc == 1) ? 32'h8 : 32'hC;
        end
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_ready_low", {31'd0, req_ready}, 32'd0);
        check("bp_rsp_held", rsp_rdata, 32'hA500_0001);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        drain();
        check("bp_rsp_count", 32'(pops), 32'd2);
        check("bp_last", last_rdata, 32'hA500_0002);
        single(1'b0, 32'h3C, 4'h0, 32'h0);
        drain();
        check("bp_resume", last_rdata, 32'hA500_000F);

        // Out-of-window read and write.
        single(1'b0, 32'h0001_0000, 4'h0, 32'h0);
        drain();
        check("oow_err", {31'd0, last_err}, 32'd1);
        check("oow_rdata", last_rdata, 32'h0);
        single(1'b1, 32'h0001_0000, 4'hF, 32'h1234_5678);
        single(1'b0, 32'h0000_0000, 4'h0, 32'h0);
        drain();
        check("oow_mem_intact", last_rdata, 32'hA500_0000);

        // Reset with two responses buffered.
        rsp_ready = 1'b0;
        issue(1'b0, 32'h4, 4'h0, 32'h0, w);
        issue(1'b0, 32'h8, 4'h0, 32'h0, w);
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_valid", {31'd0, rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        check("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        sq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; rsp_ready = 1'b1; pops = 0;
        single(1'b0, 32'hC, 4'h0, 32'h0);
        drain();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_count", 32'(pops), 32'd1);
        check("post_rst_rdata", last_rdata, 32'hA500_0003);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sram_req_ctrl.md
Name: sram_req_ctrl

Overview:
- Request/response front end that sits directly upstream of the single-port 16K x 32 on-chip SRAM macro. Accepts valid/ready memory requests from the bus/core side and drives the macro's CS/WE/A/BYTE/DI pins.
- Captures DO one cycle after each issued read and returns in-order responses through a small buffer, so the upstream side may apply backpressure without stalling the macro's fixed 1-cycle read latency.
- Out-of-window addresses return an error response without touching the array.

Parameters:
- BASE, 32'h0000_0000, byte base address of the SRAM window; must be 64 KiB aligned.
- RSP_DEPTH, 2, response buffer entries; must be >= 2 to sustain one request per cycle.

Ports:
- clk  input  1  clock; also drives the SRAM macro CK.
- rst  input  1  asynchronous reset, active-high.
- req_valid  input  1  request valid.
- req_ready  output  1  request accepted when req_valid & req_ready (req_fire).
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  byte address; bits [1:0] ignored.
- req_byte  input  4  write byte enables; ignored for reads.
- req_wdata  input  32  write data.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumed when rsp_valid & rsp_ready (rsp_fire).
- rsp_rdata  output  32  read data; 0 for writes and errors.
- rsp_err  output  1  address was outside [BASE, BASE+64KiB).
- sram_cs  output  1  macro chip select.
- sram_we  output  1  macro write enable.
- sram_a  output  14  macro word address.
- sram_byte  output  4  macro byte enables.
- sram_di  output  32  macro write data.
- sram_do  input  32  macro read data, valid the cycle after a read with CS=1.

Behaviour:
- Reset (async, while rst=1): pend_v=0, buffer empty, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0. SRAM contents are not altered.
- Address decode: hit = (req_addr[31:16] == BASE[31:16]); err = !hit.
- SRAM pins are combinational from the request:
  - sram_cs = req_fire & hit
  - sram_we = req_write
  - sram_a = req_addr[15:2]
  - sram_byte = req_byte
  - sram_di = req_wdata
  - The macro registers these on the same clk edge as req_fire.
- Pending stage, registered on each clk edge: pend_v <= req_fire; pend_write <= req_write; pend_err <= err.
- Buffer push, in the cycle after req_fire (pend_v=1): push {rdata, err} where rdata = sram_do if (!pend_write & !pend_err), else 0. Every request, including writes and errors, yields exactly one response, in order.
- Buffer pop: on rsp_fire. rsp_valid, rsp_rdata and rsp_err come from the buffer head only; there is no bypass.
- Latency: req_fire in cycle t -> rsp_valid in cycle t+2 when the buffer is empty.
- Occupancy: occ = buffer count + pend_v. req_ready = !rst & ((occ - rsp_fire) < RSP_DEPTH). req_ready may depend combinationally on rsp_ready.
- Throughput: sustained one request per cycle when rsp_ready=1.
- Full buffer: when occ == RSP_DEPTH and no rsp_fire, req_ready=0 and the SRAM is not selected.
- Simultaneous push and pop in one cycle: count unchanged, head advances.
- Buffer pointers wrap modulo RSP_DEPTH.
- A read issued the cycle after a write to the same word returns the new data, because the macro updates on the write edge.
- rsp_valid/rsp_rdata/rsp_err hold stable while rsp_valid & !rsp_ready.
- Reset asserted mid-operation: all in-flight and buffered responses are discarded; req_ready=0 until rst deasserts.

Test Plan:
- Write 0xDEADBEEF to BASE+0x10 with byte=4'hF, then read BASE+0x10 -> write rsp {rdata=0, err=0}; read rsp rdata=0xDEADBEEF, rsp_valid 2 cycles after the read's req_fire.
- Partial write byte=4'b0101, wdata=0x11223344, over word 0xFFFFFFFF, then read -> rdata=0xFF22FF44.
- Back-to-back reads of addresses 0x0..0x3C with rsp_ready=1 -> req_ready stays 1, one rsp per cycle, data in issue order.
- rsp_ready held 0 while issuing reads -> exactly 2 accepted and req_ready drops to 0; sram_cs=0 while stalled; release rsp_ready -> both responses delivered in order, then acceptance resumes.
- Read at BASE+0x10000 -> sram_cs=0, rsp_err=1, rdata=0. Write at the same address -> memory unchanged (verified by re-reading BASE+0x0).
- Assert rst with 2 responses buffered -> rsp_valid=0 immediately; after deassert, the first new read returns only its own response.
